// File: rtl/pwm_pkg.sv
// Shared types and constants for the breathing duty-cycle sequencer.
//   breath_state_t : sequencer FSM states
//   breath_mode_t  : sequence selected on the mode input
//   DUTY_FULL      : highest duty the PWM generator accepts (percent)
//   US_PER_S       : microseconds per second, used to derive the 1 us prescale
package pwm_pkg;

   localparam int unsigned DUTY_FULL = 100;
   localparam int unsigned US_PER_S  = 1_000_000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RISE    = 3'd1,
      ST_HOLD_HI = 3'd2,
      ST_FALL    = 3'd3,
      ST_HOLD_LO = 3'd4,
      ST_DONE    = 3'd5
   } breath_state_t;

   typedef enum logic [1:0] {
      MODE_BREATH    = 2'd0,
      MODE_RISE_ONCE = 2'd1,
      MODE_FALL_ONCE = 2'd2,
      MODE_STATIC    = 2'd3
   } breath_mode_t;

   function automatic logic [15:0] min_u16(input logic [15:0] a, input logic [15:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler producing a single-cycle tick every DIV clocks.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear; while high no tick, and the count restarts
//           so the first tick after clr drops comes DIV clocks later
//   tick  : one-cycle pulse
module pwm_tick_gen #(
   parameter int unsigned DIV = 50
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick = !clr && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (clr || (cnt_q == '0)) begin
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_breath_ramp.sv
// Duty-cycle sequencer feeding a 0..100 % PWM generator: breathing loop,
// one-shot soft-start / soft-stop, or static duty, stepped in microseconds.
//   clk        : system clock (CLK_FRE Hz, integer multiple of 1 MHz)
//   rst_n      : asynchronous active-low reset
//   en         : 1 = run the selected sequence, 0 = idle with duty 0
//   mode       : 0 breath, 1 rise once, 2 fall once, 3 static (sampled at start)
//   duty_min   : lower duty limit, percent
//   duty_max   : upper duty limit, percent (clamped to 100)
//   step_us    : microseconds per 1 % step (0 acts as 1)
//   hold_steps : step periods to dwell at each extreme while breathing
//   pwm_duty   : registered duty to the PWM generator
//   busy       : registered, high whenever the sequencer is not idle
//   cycle_done : registered one-cycle pulse at the end of a ramp / breath
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | duty 0, waiting for en to be seen high for a full cycle
// ST_RISE    | duty +1 per step until eff_max
// ST_HOLD_HI | breathing dwell at eff_max for hold_steps steps
// ST_FALL    | duty -1 per step until eff_min
// ST_HOLD_LO | breathing dwell at eff_min for hold_steps steps
// ST_DONE    | one-shot finished, duty follows the active limit
module pwm_breath_ramp #(
   parameter int unsigned CLK_FRE = 50_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [15:0] duty_min,
   input  logic [15:0] duty_max,
   input  logic [15:0] step_us,
   input  logic [7:0]  hold_steps,
   output logic [15:0] pwm_duty,
   output logic        busy,
   output logic        cycle_done
);

   import pwm_pkg::*;

   localparam int unsigned DIV = CLK_FRE / US_PER_S;

   breath_state_t state_q, state_d;
   breath_mode_t  mode_q, mode_d;
   logic [15:0]   duty_q, duty_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          en_q;
   logic [15:0]   step_cnt_q, step_cnt_d;
   logic [7:0]    hold_cnt_q, hold_cnt_d;

   logic [15:0] eff_max;
   logic [15:0] eff_min;
   logic [15:0] step_len;
   logic        clr_tmr;
   logic        us_tick;
   logic        step_evt;
   logic [15:0] rise_val;
   logic [15:0] fall_val;
   logic        is_breath;

   assign eff_max  = min_u16(duty_max, 16'(DUTY_FULL));
   assign eff_min  = min_u16(duty_min, eff_max);
   assign step_len = (step_us == 16'd0) ? 16'd1 : step_us;

   // Timers only run while a sequence is active; holding them clear in IDLE
   // makes the first step land exactly step_us after entry.
   assign clr_tmr = !en || (state_q == ST_IDLE);

   pwm_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_tmr),
      .tick  (us_tick)
   );

   // Step timer: down-counter reloaded with step_len-1, event at zero.
   always_comb begin
      step_cnt_d = step_cnt_q;
      step_evt   = 1'b0;
      if (clr_tmr) begin
         step_cnt_d = step_len - 16'd1;
      end else if (us_tick) begin
         if (step_cnt_q == 16'd0) begin
            step_evt   = 1'b1;
            step_cnt_d = step_len - 16'd1;
         end else begin
            step_cnt_d = step_cnt_q - 16'd1;
         end
      end
   end

   // Next ramp values compare before +/-1 so the 16-bit duty never wraps,
   // then clamp into the live limits in case they moved mid-run.
   always_comb begin
      rise_val = (duty_q >= eff_max) ? eff_max : duty_q + 16'd1;
      if (rise_val < eff_min) begin
         rise_val = eff_min;
      end
      fall_val = (duty_q <= eff_min) ? eff_min : duty_q - 16'd1;
      if (fall_val > eff_max) begin
         fall_val = eff_max;
      end
   end

   assign is_breath = (mode_q == MODE_BREATH);

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      duty_d     = duty_q;
      done_d     = 1'b0;
      hold_cnt_d = hold_cnt_q;

      if (!en) begin
         state_d    = ST_IDLE;
         duty_d     = 16'd0;
         hold_cnt_d = 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               duty_d = 16'd0;
               if (en_q) begin
                  mode_d = breath_mode_t'(mode);
                  case (breath_mode_t'(mode))
                     MODE_BREATH, MODE_RISE_ONCE: begin
                        state_d = ST_RISE;
                        duty_d  = eff_min;
                     end
                     MODE_FALL_ONCE: begin
                        state_d = ST_FALL;
                        duty_d  = eff_max;
                     end
                     default: begin
                        state_d = ST_DONE;
                        duty_d  = eff_max;
                     end
                  endcase
               end
            end

            ST_RISE: begin
               if (step_evt) begin
                  duty_d = rise_val;
                  if (rise_val >= eff_max) begin
                     if (!is_breath) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                     end else if (hold_steps != 8'd0) begin
                        state_d    = ST_HOLD_HI;
                        hold_cnt_d = hold_steps;
                     end else begin
                        state_d = ST_FALL;
                     end
                  end
               end
            end

            ST_HOLD_HI: begin
               if (step_evt) begin
                  if (hold_cnt_q <= 8'd1) begin
                     state_d    = ST_FALL;
                     hold_cnt_d = 8'd0;
                  end else begin
                     hold_cnt_d = hold_cnt_q - 8'd1;
                  end
               end
            end

            ST_FALL: begin
               if (step_evt) begin
                  duty_d = fall_val;
                  if (fall_val <= eff_min) begin
                     done_d = 1'b1;
                     if (!is_breath) begin
                        state_d = ST_DONE;
                     end else if (hold_steps != 8'd0) begin
                        state_d    = ST_HOLD_LO;
                        hold_cnt_d = hold_steps;
                     end else begin
                        state_d = ST_RISE;
                     end
                  end
               end
            end

            ST_HOLD_LO: begin
               if (step_evt) begin
                  if (hold_cnt_q <= 8'd1) begin
                     state_d    = ST_RISE;
                     hold_cnt_d = 8'd0;
                  end else begin
                     hold_cnt_d = hold_cnt_q - 8'd1;
                  end
               end
            end

            ST_DONE: begin
               duty_d = (mode_q == MODE_FALL_ONCE) ? eff_min : eff_max;
            end

            default: begin
               state_d = ST_IDLE;
               duty_d  = 16'd0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_BREATH;
         duty_q     <= 16'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         en_q       <= 1'b0;
         step_cnt_q <= 16'd0;
         hold_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         duty_q     <= duty_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         en_q       <= en;
         step_cnt_q <= step_cnt_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign pwm_duty   = duty_q;
   assign busy       = busy_q;
   assign cycle_done = done_q;

endmodule
